// File: rtl/audio_pkg.sv
// Shared audio types: sample width, the silence code and the stereo pair
// layout used by the feeder, the DAC wrapper and mixers.
package audio_pkg;

  localparam int SAMPLE_W = 8;

  // Excess-128 samples: mid-scale is silence.
  localparam logic [SAMPLE_W-1:0] SILENCE = 8'h80;

  // Left channel occupies the upper byte.
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_pair_t;

  localparam stereo_pair_t SILENT_PAIR = '{left: SILENCE, right: SILENCE};

  function automatic stereo_pair_t make_pair(input logic [SAMPLE_W-1:0] l,
                                             input logic [SAMPLE_W-1:0] r);
    stereo_pair_t p;
    p.left  = l;
    p.right = r;
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port. The read register is
// written only on a read request; a request on an empty FIFO loads FILL so
// the consumer gets a defined value without an extra mux stage.
module sync_fifo #(
  parameter int                 WIDTH = 16,
  parameter int                 DEPTH = 16,
  parameter logic [WIDTH-1:0]   FILL  = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [LVL_W-1:0] level_next;
  logic [WIDTH-1:0] rd_data_reg;
  logic             wr_fire;
  logic             rd_fire;

  // Full/empty come from the level register only, so the write-side ready
  // has no combinational path from the request inputs.
  assign full    = (level_reg == LVL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign level   = level_reg;
  assign rd_data = rd_data_reg;

  // Level bookkeeping: simultaneous push and pop leave it unchanged.
  always_comb begin
    level_next = level_reg;
    case ({wr_fire, rd_fire})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  // Storage array: write only, no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers and level; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_fire) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_next;
    end
  end

  // Registered read; reads the old contents when a write lands the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data_reg <= FILL;
    end else if (rd_en) begin
      rd_data_reg <= rd_fire ? mem[rd_ptr_reg] : FILL;
    end
  end

endmodule

// File: rtl/stereo_sample_feeder.sv
// Paces stereo PCM pairs from a loader FIFO out to the DACs, one pair per
// prescaler period, substituting silence and flagging underrun when starved.
module stereo_sample_feeder
  import audio_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int PRESCALE = 6999
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [7:0]               wr_left,
  input  logic [7:0]               wr_right,
  output logic [7:0]               left_sample,
  output logic [7:0]               right_sample,
  output logic                     sample_strobe,
  output logic                     underrun,
  input  logic                     clear_underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int CNT_W = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             tick;
  logic             strobe_reg;
  logic             underrun_reg;
  logic             underrun_next;
  logic             fifo_full;
  logic             fifo_empty;
  stereo_pair_t     wr_pair;
  stereo_pair_t     rd_pair;

  assign wr_pair = make_pair(wr_left, wr_right);

  // Loader FIFO; its read register doubles as the DAC output register.
  sync_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (DEPTH),
    .FILL  (SILENT_PAIR)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_valid),
    .wr_data (wr_pair),
    .rd_en   (tick),
    .rd_data (rd_pair),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Prescaler next value and sample-slot tick; frozen while disabled.
  always_comb begin
    count_next = count_reg;
    tick       = enable && (count_reg == CNT_W'(PRESCALE));
    if (enable) begin
      count_next = tick ? '0 : count_reg + CNT_W'(1);
    end
  end

  // Sticky underrun: a starved slot overrides a same-cycle clear.
  always_comb begin
    underrun_next = underrun_reg;
    if (clear_underrun) underrun_next = 1'b0;
    if (tick && fifo_empty) underrun_next = 1'b1;
  end

  // Prescaler, strobe and underrun registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg    <= '0;
      strobe_reg   <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      strobe_reg   <= tick;
      underrun_reg <= underrun_next;
    end
  end

  assign wr_ready      = !fifo_full;
  assign left_sample   = rd_pair.left;
  assign right_sample  = rd_pair.right;
  assign sample_strobe = strobe_reg;
  assign underrun      = underrun_reg;

endmodule

// File: tb/tb_stereo_sample_feeder.sv
// Directed bench for stereo_sample_feeder with DEPTH=4, PRESCALE=9.
module tb_stereo_sample_feeder;

  localparam int DEPTH    = 4;
  localparam int PRESCALE = 9;
  localparam int LVL_W    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             wr_valid = 1'b0;
  logic [7:0]       wr_left = 8'h00;
  logic [7:0]       wr_right = 8'h00;
  logic             clear_underrun = 1'b0;
  logic             wr_ready;
  logic [7:0]       left_sample;
  logic [7:0]       right_sample;
  logic             sample_strobe;
  logic             underrun;
  logic [LVL_W-1:0] level;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0] exp_left;
    logic [7:0] exp_right;
    logic       exp_underrun;
    int         exp_level;
  } play_vec_t;

  play_vec_t  play_tab[4];
  logic [7:0] push_l[3];
  logic [7:0] push_r[3];

  stereo_sample_feeder #(.DEPTH(DEPTH), .PRESCALE(PRESCALE)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_left        (wr_left),
    .wr_right       (wr_right),
    .left_sample    (left_sample),
    .right_sample   (right_sample),
    .sample_strobe  (sample_strobe),
    .underrun       (underrun),
    .clear_underrun (clear_underrun),
    .level          (level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %s: got %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_strobe && n < limit);
  endtask

  task automatic push_now(input logic [7:0] l, input logic [7:0] r);
    wr_valid = 1'b1;
    wr_left  = l;
    wr_right = r;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    int n;
    int accepts;
    int strobes;

    push_l = '{8'h10, 8'h20, 8'h30};
    push_r = '{8'hF0, 8'hE0, 8'hD0};
    play_tab[0] = '{exp_left: 8'h10, exp_right: 8'hF0, exp_underrun: 1'b0, exp_level: 2};
    play_tab[1] = '{exp_left: 8'h20, exp_right: 8'hE0, exp_underrun: 1'b0, exp_level: 1};
    play_tab[2] = '{exp_left: 8'h30, exp_right: 8'hD0, exp_underrun: 1'b0, exp_level: 0};
    play_tab[3] = '{exp_left: 8'h80, exp_right: 8'h80, exp_underrun: 1'b1, exp_level: 0};

    // Reset and idle
    enable  = 1'b1;
    reset_n = 1'b0;
    step();
    check("rst_left", 32'(left_sample), 32'h80);
    check("rst_right", 32'(right_sample), 32'h80);
    check("rst_strobe", 32'(sample_strobe), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_level", 32'(level), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    reset_n = 1'b1;
    wait_strobe(30, n);
    check("first_strobe_delay", 32'(n), 10);
    check("first_strobe_underrun", 32'(underrun), 1);
    check("first_strobe_left", 32'(left_sample), 32'h80);
    step();
    check("strobe_one_cycle", 32'(sample_strobe), 0);
    wait_strobe(30, n);
    check("idle_period", 32'(n), 9);

    // Clear, push three pairs, play them out from the table
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    check("clear_underrun", 32'(underrun), 0);
    for (int i = 0; i < 3; i++) push_now(push_l[i], push_r[i]);
    check("level_after_3", 32'(level), 3);
    for (int i = 0; i < 4; i++) begin
      wait_strobe(30, n);
      if (i > 0) check($sformatf("play%0d_period", i), 32'(n), 10);
      check($sformatf("play%0d_left", i), 32'(left_sample), 32'(play_tab[i].exp_left));
      check($sformatf("play%0d_right", i), 32'(right_sample), 32'(play_tab[i].exp_right));
      check($sformatf("play%0d_underrun", i), 32'(underrun), 32'(play_tab[i].exp_underrun));
      check($sformatf("play%0d_level", i), 32'(level), 32'(play_tab[i].exp_level));
    end
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    check("clear_after_play", 32'(underrun), 0);

    // Fill beyond DEPTH while disabled (prescaler parked at 1)
    enable  = 1'b0;
    accepts = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_valid = 1'b1;
      wr_left  = 8'h40 + 8'(i);
      wr_right = 8'hC0 - 8'(i);
      if (wr_ready) accepts++;
      step();
    end
    wr_valid = 1'b0;
    check("full_accepts", 32'(accepts), DEPTH);
    check("full_level", 32'(level), DEPTH);
    check("full_wr_ready", 32'(wr_ready), 0);
    strobes = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (sample_strobe) strobes++;
    end
    check("disabled_no_strobe", 32'(strobes), 0);
    check("disabled_left_held", 32'(left_sample), 32'h80);
    enable = 1'b1;
    wait_strobe(30, n);
    check("resume_delay", 32'(n), 9);
    check("resume_left", 32'(left_sample), 32'h40);
    check("resume_right", 32'(right_sample), 32'hC0);
    check("resume_level", 32'(level), DEPTH - 1);
    check("resume_wr_ready", 32'(wr_ready), 1);
    for (int i = 1; i < DEPTH; i++) begin
      wait_strobe(30, n);
      check($sformatf("drain%0d_left", i), 32'(left_sample), 32'h40 + 32'(i));
    end
    wait_strobe(30, n);
    check("drain_underrun", 32'(underrun), 1);
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;

    // Push coinciding with a tick at level 1
    wait_strobe(30, n);
    push_now(8'h5A, 8'hA5);
    for (int i = 0; i < 8; i++) step();
    push_now(8'h6B, 8'hB6);
    check("pt1_strobe", 32'(sample_strobe), 1);
    check("pt1_left", 32'(left_sample), 32'h5A);
    check("pt1_level", 32'(level), 1);
    wait_strobe(30, n);
    check("pt1_next_period", 32'(n), 10);
    check("pt1_next_left", 32'(left_sample), 32'h6B);
    check("pt1_next_right", 32'(right_sample), 32'hB6);
    check("pt1_next_level", 32'(level), 0);

    // Push on the tick cycle at level 0, with a clear that must lose
    for (int i = 0; i < 9; i++) step();
    clear_underrun = 1'b1;
    push_now(8'h7C, 8'hC7);
    clear_underrun = 1'b0;
    check("pt0_strobe", 32'(sample_strobe), 1);
    check("pt0_left", 32'(left_sample), 32'h80);
    check("pt0_underrun_wins", 32'(underrun), 1);
    check("pt0_level", 32'(level), 1);
    wait_strobe(30, n);
    check("pt0_next_period", 32'(n), 10);
    check("pt0_next_left", 32'(left_sample), 32'h7C);

    // Pause at count 5 for 20 cycles
    for (int i = 0; i < 5; i++) step();
    enable  = 1'b0;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sample_strobe) strobes++;
    end
    check("pause_no_strobe", 32'(strobes), 0);
    enable = 1'b1;
    wait_strobe(30, n);
    check("pause_resume_delay", 32'(n), 5);

    // Reset mid-stream discards stored pairs
    push_now(8'h11, 8'h22);
    wait_strobe(30, n);
    check("pre_reset_left", 32'(left_sample), 32'h11);
    push_now(8'h33, 8'h44);
    push_now(8'h55, 8'h66);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_left", 32'(left_sample), 32'h80);
    check("mid_rst_right", 32'(right_sample), 32'h80);
    check("mid_rst_underrun", 32'(underrun), 0);
    check("mid_rst_wr_ready", 32'(wr_ready), 1);
    wait_strobe(30, n);
    check("mid_rst_restart", 32'(n), 10);
    check("mid_rst_underrun_after", 32'(underrun), 1);
    check("mid_rst_left_after", 32'(left_sample), 32'h80);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
